// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the cache-to-RAM path
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates icache/dcache requests onto the single RAM port
// dcache has priority; a saturating streak counter forces icache after MAX_D_STREAK dcache wins.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int SW           = 3
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state, next_state;
    logic [SW-1:0] streak, streak_next;
    logic          d_req;
    logic          force_i;

    assign d_req   = dREN | dWEN;
    assign force_i = iREN & (streak >= STREAK_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= streak_next;
        end
    end

    always_comb begin
        next_state  = state;
        streak_next = streak;
        unique case (state)
            IDLE: begin
                if (d_req && !force_i)
                    next_state = DACC;
                else if (iREN)
                    next_state = IACC;
            end
            IACC: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    next_state  = IDLE;
                    streak_next = '0;
                end
            end
            DACC: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    next_state = IDLE;
                    // Count dcache wins only while icache is actually starving.
                    if (!iREN)
                        streak_next = '0;
                    else if (streak < STREAK_MAX)
                        streak_next = streak + 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state)
            IACC: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            DACC: begin
                if (d_req) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait = 1'b0;
                        dload = dWEN ? '0 : ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    mem_arbiter #(.MAX_D_STREAK(4), .SW(3)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit    is_d;
        bit    wen;
        word_t addr;
        word_t data;
        int    nbusy;
        int    nerr;
        word_t rload;
        word_t exp_load;
    } vec_t;

    typedef struct {
        bit    is_d;
        word_t load;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (!iwait || !dwait) begin
            chk("single_wait", 32'(!iwait && !dwait), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, iwait, dwait}, 32'h3);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant_side", 32'(!dwait), 32'(e.is_d));
                chk("load_data", dwait ? iload : dload, e.load);
            end
        end
    end

    task automatic chk_strobes(input vec_t v, input string tag);
        chk({tag, "_ramREN"}, 32'(ramREN), v.is_d ? 32'(!v.wen) : 32'd1);
        chk({tag, "_ramWEN"}, 32'(ramWEN), 32'(v.is_d && v.wen));
        chk({tag, "_ramaddr"}, ramaddr, v.addr);
        chk({tag, "_ramstore"}, ramstore, v.is_d ? v.data : 32'd0);
    endtask

    task automatic txn(input vec_t v);
        if (v.is_d) begin
            dREN = !v.wen; dWEN = v.wen; daddr = v.addr; dstore = v.data;
        end else begin
            iREN = 1'b1; iaddr = v.addr;
        end
        ramstate = FREE;
        cyc();
        chk_strobes(v, "first");
        for (int i = 0; i < v.nbusy + v.nerr; i++) begin
            ramstate = (i < v.nbusy) ? BUSY : ERROR;
            ramload  = $urandom;
            cyc();
            chk_strobes(v, "hold");
        end
        ramstate = ACCESS;
        ramload  = v.rload;
        sb.push_back('{v.is_d, v.exp_load});
        cyc();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramstate = FREE;
        chk("drained", sb.size(), 0);
        chk("idle_ramREN", 32'(ramREN), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h40,       32'h0,        2, 0, 32'h8C010004, 32'h8C010004};
        vecs[1] = '{1'b1, 1'b0, 32'h100,      32'h0,        0, 0, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'h80,       32'hCAFEF00D, 1, 0, 32'h55555555, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h200,      32'h0,        0, 3, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF};

        // Reset with random inputs
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iREN = 1'($urandom); dREN = 1'($urandom); dWEN = 1'($urandom);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = ramstate_t'(2'($urandom));
            cyc();
            chk("rst_iwait", 32'(iwait), 32'd1);
            chk("rst_dwait", 32'(dwait), 32'd1);
            chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
            chk("rst_loads", iload | dload, 32'd0);
        end
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        ramstate = FREE;
        cyc();
        RST = 1'b0;
        cyc();

        for (int k = 0; k < 5; k++) txn(vecs[k]);

        // Simultaneous iREN and dWEN: dcache first, icache next
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        ramstate = FREE;
        cyc();
        chk("sim_ramWEN", 32'(ramWEN), 32'd1);
        chk("sim_ramREN", 32'(ramREN), 32'd0);
        chk("sim_ramstore", ramstore, 32'hDEADBEEF);
        chk("sim_ramaddr", ramaddr, 32'h80);
        ramstate = ACCESS; sb.push_back('{1'b1, 32'h0});
        cyc();
        dWEN = 0; ramstate = FREE;
        chk("sim_drain_d", sb.size(), 0);
        cyc();
        chk("sim_i_ramREN", 32'(ramREN), 32'd1);
        chk("sim_i_ramaddr", ramaddr, 32'h44);
        ramstate = ACCESS; ramload = 32'h11112222; sb.push_back('{1'b0, 32'h11112222});
        cyc();
        iREN = 0; ramstate = FREE;
        chk("sim_drain_i", sb.size(), 0);

        // Starvation: four dcache grants, one forced icache grant, then dcache again
        iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h800;
        for (int k = 0; k < 6; k++) begin
            bit exp_d;
            exp_d = (k != 4);
            cyc();
            chk("streak_addr", ramaddr, exp_d ? 32'h800 : 32'h400);
            ramstate = ACCESS; ramload = 32'(k) + 32'h100;
            sb.push_back('{exp_d, 32'(k) + 32'h100});
            cyc();
            ramstate = FREE;
        end
        iREN = 0; dREN = 0;
        chk("streak_drain", sb.size(), 0);
        cyc();

        // icache drops its request mid-access: strobes fall in the same cycle
        iREN = 1; iaddr = 32'h60;
        cyc();
        chk("abort_ramREN_on", 32'(ramREN), 32'd1);
        ramstate = BUSY; iREN = 0;
        #1;
        chk("abort_ramREN_off", 32'(ramREN), 32'd0);
        chk("abort_ramaddr", ramaddr, 32'd0);
        cyc();
        ramstate = ACCESS;
        #1;
        chk("abort_idle", 32'(ramREN), 32'd0);
        ramstate = FREE;
        cyc();

        // Reset mid-IACC: no completion, IDLE after release
        iREN = 1; iaddr = 32'h70;
        cyc();
        ramstate = BUSY;
        #1;
        chk("rstmid_ramREN_on", 32'(ramREN), 32'd1);
        RST = 1;
        #1;
        chk("rstmid_ramREN_off", 32'(ramREN), 32'd0);
        chk("rstmid_iwait", 32'(iwait), 32'd1);
        ramstate = ACCESS;
        cyc();
        cyc();
        iREN = 0; RST = 0; ramstate = FREE;
        cyc();
        chk("rstmid_idle_ramREN", 32'(ramREN), 32'd0);
        chk("rstmid_idle_iwait", 32'(iwait), 32'd1);
        chk("final_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
